jr_target_unit: RTL and testbench

JR_TARGET_UNIT -- requirements
Module: jr_target_unit

---
 rtl/mips_pipe_pkg.sv | 13 +
 rtl/jr_operand_mux.sv | 24 ++
 rtl/jr_target_unit.sv | 121 ++++++++++++
 tb/tb_jr_target_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the jr/jalr target path: forward select codes and FSM state values.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] JR_IDLE  = 2'd0;
  localparam logic [1:0] JR_WAIT  = 2'd1;
  localparam logic [1:0] JR_ISSUE = 2'd2;

endpackage

// File: rtl/jr_operand_mux.sv
// Combinational 4:1 selector for the jr rs operand: register file or a forwarded pipeline value.
module jr_operand_mux
  import mips_pipe_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] rd1_D,
  input  logic [31:0] pc8_E,
  input  logic [31:0] ao_M,
  input  logic [31:0] wd_W,
  output logic [31:0] operand
);

  always_comb begin
    operand = rd1_D;
    case (sel)
      FWD_RF:  operand = rd1_D;
      FWD_E:   operand = pc8_E;
      FWD_M:   operand = ao_M;
      FWD_W:   operand = wd_W;
      default: operand = rd1_D;
    endcase
  end

endmodule

// File: rtl/jr_target_unit.sv
// jr/jalr target resolution: waits out rs hazards, captures the target and hands it to fetch.
// Optional stall counter enabled by defining JR_STALL_CNT_EN.
module jr_target_unit
  import mips_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        jr_valid_D,
  input  logic        hazard_stall,
  input  logic [1:0]  forward_rs_jr,
  input  logic [31:0] rd1_D,
  input  logic [31:0] pc8_E,
  input  logic [31:0] ao_M,
  input  logic [31:0] wd_W,
  input  logic        flush,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        hold_D,
  output logic        align_err,
  output logic [31:0] stall_cnt
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        align_q, align_d;
  logic [31:0] operand;
  logic        capture;
  logic        misaligned;

  jr_operand_mux u_operand_mux (
    .sel     (forward_rs_jr),
    .rd1_D   (rd1_D),
    .pc8_E   (pc8_E),
    .ao_M    (ao_M),
    .wd_W    (wd_W),
    .operand (operand)
  );

  assign misaligned = (operand[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    align_d = 1'b0;
    capture = 1'b0;
    case (state_q)
      JR_IDLE: begin
        if (jr_valid_D) begin
          if (hazard_stall) state_d = JR_WAIT;
          else              capture = 1'b1;
        end
      end
      JR_WAIT: begin
        if (!hazard_stall) capture = 1'b1;
      end
      JR_ISSUE: begin
        if (redirect_ready) state_d = JR_IDLE;
      end
      default: state_d = JR_IDLE;
    endcase
    // A misaligned target is dropped without touching the held redirect_pc.
    if (capture) begin
      if (misaligned) begin
        align_d = 1'b1;
        state_d = JR_IDLE;
      end else begin
        pc_d    = operand;
        state_d = JR_ISSUE;
      end
    end
    if (flush) begin
      state_d = JR_IDLE;
      pc_d    = pc_q;
      align_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= JR_IDLE;
      pc_q    <= 32'h0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      align_q <= align_d;
    end
  end

  always_comb begin
    hold_D = 1'b0;
    case (state_q)
      JR_IDLE:  hold_D = jr_valid_D & hazard_stall;
      JR_WAIT:  hold_D = 1'b1;
      JR_ISSUE: hold_D = ~redirect_ready;
      default:  hold_D = 1'b0;
    endcase
  end

  assign redirect_valid = (state_q == JR_ISSUE);
  assign redirect_pc    = pc_q;
  assign align_err      = align_q;

`ifdef JR_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
    end else if (hold_D && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_jr_target_unit.sv
// Directed self-checking bench for jr_target_unit.
module tb_jr_target_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jr_valid_D = 1'b0;
  logic        hazard_stall = 1'b0;
  logic [1:0]  forward_rs_jr = 2'd0;
  logic [31:0] rd1_D = 32'h0;
  logic [31:0] pc8_E = 32'h0;
  logic [31:0] ao_M = 32'h0;
  logic [31:0] wd_W = 32'h0;
  logic        flush = 1'b0;
  logic        redirect_ready = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        hold_D;
  logic        align_err;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  jr_target_unit dut (
    .clk            (clk),
    .reset          (reset),
    .jr_valid_D     (jr_valid_D),
    .hazard_stall   (hazard_stall),
    .forward_rs_jr  (forward_rs_jr),
    .rd1_D          (rd1_D),
    .pc8_E          (pc8_E),
    .ao_M           (ao_M),
    .wd_W           (wd_W),
    .flush          (flush),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hold_D         (hold_D),
    .align_err      (align_err),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", redirect_valid);
    end
    checks++;
    if (redirect_pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want 00000000", redirect_pc);
    end
    checks++;
    if (align_err !== 1'b0) begin
      errors++; $display("FAIL reset_align: got %b want 0", align_err);
    end
    checks++;
    if (hold_D !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %b want 0", hold_D);
    end
    checks++;
    if (stall_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %h want 00000000", stall_cnt);
    end
  endtask

  task automatic test_hazard_free;
    jr_valid_D = 1'b1; hazard_stall = 1'b0; forward_rs_jr = 2'd0;
    rd1_D = 32'h0000_3010; redirect_ready = 1'b1;
    #1;
    checks++;
    if (hold_D !== 1'b0) begin
      errors++; $display("FAIL hf_hold_capture: got %b want 0", hold_D);
    end
    tick();
    jr_valid_D = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_3010) begin
      errors++;
      $display("FAIL hf_issue: got valid=%b pc=%h want valid=1 pc=00003010",
               redirect_valid, redirect_pc);
    end
    checks++;
    if (hold_D !== 1'b0) begin
      errors++; $display("FAIL hf_hold_issue: got %b want 0", hold_D);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || hold_D !== 1'b0) begin
      errors++;
      $display("FAIL hf_idle: got valid=%b hold=%b want 0 0", redirect_valid, hold_D);
    end
  endtask

  task automatic test_stall_forward;
    int holds;
    holds = 0;
    jr_valid_D = 1'b1; hazard_stall = 1'b1; redirect_ready = 1'b1;
    forward_rs_jr = 2'd2; ao_M = 32'h0000_1111;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (hold_D === 1'b1) holds++;
      tick();
    end
    hazard_stall = 1'b0; ao_M = 32'h0000_3400;
    #1;
    if (hold_D === 1'b1) holds++;
    tick();
    jr_valid_D = 1'b0;
    #1;
    if (hold_D === 1'b1) holds++;
    checks++;
    if (holds !== 3) begin
      errors++; $display("FAIL sf_hold_cycles: got %0d want 3", holds);
    end
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_3400) begin
      errors++;
      $display("FAIL sf_issue: got valid=%b pc=%h want valid=1 pc=00003400",
               redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++; $display("FAIL sf_idle: got %b want 0", redirect_valid);
    end
  endtask

  task automatic test_back_pressure;
    jr_valid_D = 1'b1; hazard_stall = 1'b0; forward_rs_jr = 2'd1;
    pc8_E = 32'h0000_5008; redirect_ready = 1'b0;
    tick();
    // A new jr and a changed operand while in ISSUE must not disturb the target.
    forward_rs_jr = 2'd0; rd1_D = 32'h7777_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_5008 || hold_D !== 1'b1) begin
        errors++;
        $display("FAIL bp_cycle%0d: got valid=%b pc=%h hold=%b want 1 00005008 1",
                 i, redirect_valid, redirect_pc, hold_D);
      end
      tick();
    end
    redirect_ready = 1'b1; jr_valid_D = 1'b0;
    #1;
    checks++;
    if (hold_D !== 1'b0 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake: got hold=%b valid=%b want 0 1", hold_D, redirect_valid);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got %b want 0", redirect_valid);
    end
  endtask

  task automatic test_misaligned;
    int pulses;
    int valids;
    pulses = 0; valids = 0;
    jr_valid_D = 1'b1; hazard_stall = 1'b0; forward_rs_jr = 2'd3;
    wd_W = 32'h0000_3002; redirect_ready = 1'b1;
    #1;
    checks++;
    if (align_err !== 1'b0) begin
      errors++; $display("FAIL ma_early: got %b want 0", align_err);
    end
    tick();
    jr_valid_D = 1'b0;
    #1;
    checks++;
    if (align_err !== 1'b1) begin
      errors++; $display("FAIL ma_pulse: got %b want 1", align_err);
    end
    for (int i = 0; i < 3; i++) begin
      if (align_err === 1'b1) pulses++;
      if (redirect_valid === 1'b1) valids++;
      tick();
    end
    checks++;
    if (pulses !== 1 || valids !== 0) begin
      errors++;
      $display("FAIL ma_single: got pulses=%0d valids=%0d want 1 0", pulses, valids);
    end
  endtask

  task automatic test_flush;
    jr_valid_D = 1'b1; hazard_stall = 1'b0; forward_rs_jr = 2'd0;
    rd1_D = 32'h0000_4000; redirect_ready = 1'b0;
    tick();
    jr_valid_D = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++; $display("FAIL fl_issue: got %b want 1", redirect_valid);
    end
    flush = 1'b1; redirect_ready = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || hold_D !== 1'b0) begin
      errors++;
      $display("FAIL fl_idle: got valid=%b hold=%b want 0 0", redirect_valid, hold_D);
    end
    // Flush on a misaligned capture suppresses the error pulse.
    jr_valid_D = 1'b1; forward_rs_jr = 2'd3; wd_W = 32'h0000_3001; flush = 1'b1;
    tick();
    jr_valid_D = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (align_err !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL fl_noalign: got align=%b valid=%b want 0 0", align_err, redirect_valid);
    end
    jr_valid_D = 1'b1; hazard_stall = 1'b1; forward_rs_jr = 2'd0; rd1_D = 32'h0000_6000;
    tick();
    jr_valid_D = 1'b0; hazard_stall = 1'b0; reset = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (hold_D !== 1'b1) begin
      errors++; $display("FAIL fl_wait: got hold=%b want 1", hold_D);
    end
    tick();
    reset = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || align_err !== 1'b0 ||
        hold_D !== 1'b0 || stall_cnt !== 32'h0) begin
      errors++;
      $display("FAIL fl_reset: got valid=%b pc=%h align=%b hold=%b cnt=%h want all 0",
               redirect_valid, redirect_pc, align_err, hold_D, stall_cnt);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++; $display("FAIL fl_reset_nojr: got %b want 0", redirect_valid);
    end
  endtask

`ifdef JR_STALL_CNT_EN
  task automatic test_counter;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    redirect_ready = 1'b1; forward_rs_jr = 2'd0; rd1_D = 32'h0000_2000;
    jr_valid_D = 1'b1; hazard_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    hazard_stall = 1'b0;
    tick();
    jr_valid_D = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 32'd5) begin
      errors++; $display("FAIL cnt_five: got %0d want 5", stall_cnt);
    end
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    jr_valid_D = 1'b1; hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL cnt_sat: got %h want ffffffff", stall_cnt);
    end
    jr_valid_D = 1'b0; hazard_stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
`else
  task automatic test_counter;
    jr_valid_D = 1'b1; hazard_stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (stall_cnt !== 32'h0 || hold_D !== 1'b1) begin
      errors++;
      $display("FAIL cnt_off: got cnt=%h hold=%b want 00000000 1", stall_cnt, hold_D);
    end
    jr_valid_D = 1'b0; hazard_stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_hazard_free();
    test_stall_forward();
    test_back_pressure();
    test_misaligned();
    test_flush();
    test_counter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
